// File: rtl/io_out_fifo.sv
// Output FIFO between processor stores and a downstream consumer. Stores decoded to the
// show or processed-image region are tagged and queued; the head is presented first-word-fall-through.
module io_out_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       show_enb,
    input  logic                       process_enb,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       out_ready,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_sel,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W:0]  mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             push_req, push, pop;

    // Handshake: a word leaves on any rising edge where out_valid and out_ready are both high;
    // out_valid never depends on out_ready, and the head holds until it is taken.
    always_comb begin
        push_req = we & (show_enb | process_enb);
        pop      = (count_q != '0) & out_ready;
        push     = push_req & ((count_q != CW'(DEPTH)) | pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        // A dropped store in the same cycle as a clear still leaves the flag set.
        if (clr_ovf)             ovf_d = 1'b0;
        if (push_req && !push)   ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {process_enb, wdata};
    end

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q][DATA_W-1:0];
    assign out_sel   = mem_q[rd_ptr_q][DATA_W];
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_io_out_fifo.sv
// Bench for io_out_fifo: directed scenarios plus random traffic against a queue-based model,
// with a negedge monitor that checks every word the consumer takes.
module tb_io_out_fifo;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          we, show_enb, process_enb, out_ready, clr_ovf;
  logic [DW-1:0] wdata;
  logic          out_valid, out_sel, full, empty, overflow;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;

  io_out_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .we(we), .show_enb(show_enb), .process_enb(process_enb),
    .wdata(wdata), .out_ready(out_ready), .clr_ovf(clr_ovf), .out_valid(out_valid),
    .out_data(out_data), .out_sel(out_sel), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q[$];
  int mdl_cnt = 0;
  bit mdl_ovf = 1'b0;
  bit held_v = 1'b0;
  logic [DW:0] held_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_status();
    chk("count", 64'(count), 64'(mdl_cnt));
    chk("empty", 64'(empty), 64'(mdl_cnt == 0));
    chk("full", 64'(full), 64'(mdl_cnt == DEPTH));
    chk("out_valid", 64'(out_valid), 64'(mdl_cnt != 0));
    chk("overflow", 64'(overflow), 64'(mdl_ovf));
  endtask

  // driver: called just after a rising edge; applies inputs for one cycle
  task automatic step(input logic i_we, input logic i_show, input logic i_proc,
                      input logic [DW-1:0] d, input logic rdy, input logic clr);
    bit preq, pop, acc;
    we = i_we; show_enb = i_show; process_enb = i_proc; wdata = d;
    out_ready = rdy; clr_ovf = clr;
    preq = i_we && (i_show || i_proc);
    pop  = (mdl_cnt > 0) && rdy;
    acc  = preq && ((mdl_cnt < DEPTH) || pop);
    if (acc) exp_q.push_back({i_proc, d});
    @(posedge clk); #1;
    mdl_cnt = mdl_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
    if (clr) mdl_ovf = 1'b0;
    if (preq && !acc) mdl_ovf = 1'b1;
    check_status();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && mdl_cnt > 0; i++) step(0, 0, 0, '0, 1, 0);
    chk("drain_empty", 64'(empty), 64'(1));
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, base + DW'(i), 0, 0);
  endtask

  // scoreboard monitor: compares every word taken by the consumer
  always @(negedge clk) begin
    if (!rst) begin
      if (held_v) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'({out_sel, out_data}), 64'(held_d));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 64'(1), 64'(0));
        else chk("pop_data", 64'({out_sel, out_data}), 64'(exp_q.pop_front()));
      end
      held_v = out_valid && !out_ready;
      held_d = {out_sel, out_data};
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    rst = 1'b1;
    we = 1'b1; show_enb = 1'b0; process_enb = 1'b1; wdata = 32'hDEAD_BEEF;
    out_ready = 1'b0; clr_ovf = 1'b0;
    // pushes during reset are ignored
    repeat (2) @(posedge clk);
    #1;
    check_status();
    rst = 1'b0;

    // first push after reset, process tag, no consumer
    step(1, 0, 1, 32'hA5A5_A5A5, 0, 0);
    chk("first_valid", 64'(out_valid), 64'(1));
    chk("first_data", 64'(out_data), 64'(32'hA5A5_A5A5));
    chk("first_sel", 64'(out_sel), 64'(1));
    chk("first_count", 64'(count), 64'(1));
    step(0, 0, 0, '0, 0, 0);
    drain();

    // fill 0..7 then a dropped ninth store
    fill(0);
    chk("fill_full", 64'(full), 64'(1));
    step(1, 1, 0, 32'h9, 0, 0);
    chk("ovf_set", 64'(overflow), 64'(1));
    chk("ovf_count", 64'(count), 64'(DEPTH));
    drain();
    step(0, 0, 0, '0, 0, 1);

    // push while full with a pop in the same cycle
    fill(32'h100);
    step(1, 1, 0, 32'h55, 1, 0);
    chk("fullpp_count", 64'(count), 64'(DEPTH));
    chk("fullpp_ovf", 64'(overflow), 64'(0));
    drain();

    // set beats clear
    fill(32'h200);
    step(1, 1, 0, 32'h1, 0, 0);
    step(1, 0, 1, 32'h2, 0, 1);
    chk("set_wins", 64'(overflow), 64'(1));
    step(0, 0, 0, '0, 0, 1);
    chk("clr_alone", 64'(overflow), 64'(0));
    drain();

    // 20 push/pop pairs through the pointer wrap, both tags
    step(1, 1, 0, 32'h300, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, i[0], 32'h301 + DW'(i), 1, 0);
      chk("pair_count", 64'(count), 64'(1));
    end
    drain();

    // memory-region store is ignored
    step(1, 0, 0, 32'hFFFF, 1, 0);
    chk("mem_store_ignored", 64'(count), 64'(0));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           DW'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end
    drain();
    step(0, 0, 0, '0, 0, 1);

    // asynchronous reset with three entries stored
    for (int i = 0; i < 3; i++) step(1, 0, 1, 32'h400 + DW'(i), 0, 0);
    we = 1'b0; show_enb = 1'b0; process_enb = 1'b0;
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    mdl_cnt = 0;
    mdl_ovf = 1'b0;
    held_v = 1'b0;
    chk("async_count", 64'(count), 64'(0));
    chk("async_valid", 64'(out_valid), 64'(0));
    chk("async_empty", 64'(empty), 64'(1));
    rst = 1'b0;
    @(posedge clk); #1;
    step(1, 0, 0, 32'h777, 0, 0);
    chk("post_rst_ignored", 64'(count), 64'(0));
    step(1, 1, 0, 32'h778, 0, 0);
    drain();

    chk("leftover", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
